running_sum_arbiter: RTL and testbench

- Shares one running-sum accumulation datapath between num_ch independent requesters.
- Grants requesters round-robin, at most one accepted sample per cycle.
- Keeps a separate accumulated sum and sticky overflow flag for each channel.
- Emits the updated sum of the served channel, tagged with its channel id, one cycle after acceptance.

---
 rtl/running_sum_arbiter.sv | 105 ++++++++++
 tb/tb_running_sum_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/running_sum_arbiter.sv
// running_sum_arbiter
//   Round-robin arbiter in front of a single shared accumulator. Each channel
//   owns its own running sum and a sticky overflow flag. The served
//   channel's updated sum is registered and presented one cycle after the
//   transfer, tagged with the channel index.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   en             global enable (0: no grants, sums held, clr still honoured)
//   req            per-channel request, data held stable until granted
//   data_in        packed samples, channel i at [i*data_width +: data_width]
//   clr            per-channel clear of sum and overflow flag
//   gnt            combinational one-hot (or zero) grant
//   data_out_valid one-cycle pulse per transfer
//   data_out       updated sum of the served channel
//   data_out_ch    index of the served channel
//   ovf            sticky per-channel overflow flags
module running_sum_arbiter #(
  parameter int data_width = 8,
  parameter int out_width  = 16,
  parameter int num_ch     = 4,
  parameter int id_width   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [num_ch-1:0]            req,
  input  logic [num_ch*data_width-1:0] data_in,
  input  logic [num_ch-1:0]            clr,
  output logic [num_ch-1:0]            gnt,
  output logic                         data_out_valid,
  output logic [out_width-1:0]         data_out,
  output logic [id_width-1:0]          data_out_ch,
  output logic [num_ch-1:0]            ovf
);

  logic [out_width-1:0]  sums [num_ch];
  logic [id_width-1:0]   ptr;

  logic                  gnt_any;
  logic [id_width-1:0]   gnt_idx;
  logic [id_width-1:0]   cand;
  logic [data_width-1:0] acc_data;
  logic [out_width-1:0]  acc_base;
  logic [out_width:0]    acc_full;

  // Scan from ptr upward. num_ch is a power of two, so the id_width-bit
  // addition wraps from num_ch-1 back to 0 on its own.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (en && !rst) begin
      for (int off = 0; off < num_ch; off++) begin
        cand = ptr + id_width'(off);
        if (!gnt_any && req[cand]) begin
          gnt_any   = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  // A clear coinciding with a transfer on the same channel acts as
  // clear-then-add, so the old sum is replaced by zero before adding.
  always_comb begin
    acc_data = data_in[gnt_idx*data_width +: data_width];
    acc_base = clr[gnt_idx] ? '0 : sums[gnt_idx];
    acc_full = {1'b0, acc_base} + (out_width+1)'(acc_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_ch; i++) begin
        sums[i] <= '0;
      end
      ovf            <= '0;
      ptr            <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_ch    <= '0;
    end else begin
      data_out_valid <= gnt_any;
      for (int i = 0; i < num_ch; i++) begin
        if (clr[i]) begin
          sums[i] <= '0;
          ovf[i]  <= 1'b0;
        end
      end
      // Written after the clear loop so the transfer result takes priority
      // on the granted channel.
      if (gnt_any) begin
        sums[gnt_idx] <= acc_full[out_width-1:0];
        ovf[gnt_idx]  <= (ovf[gnt_idx] & ~clr[gnt_idx]) | acc_full[out_width];
        data_out      <= acc_full[out_width-1:0];
        data_out_ch   <= gnt_idx;
        ptr           <= gnt_idx + id_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_running_sum_arbiter.sv
module tb_running_sum_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  clr;
  logic [3:0]  gnt;
  logic        data_out_valid;
  logic [15:0] data_out;
  logic [1:0]  data_out_ch;
  logic [3:0]  ovf;

  int checks = 0;
  int errors = 0;

  running_sum_arbiter #(
    .data_width(8), .out_width(16), .num_ch(4), .id_width(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .data_in(data_in), .clr(clr),
    .gnt(gnt), .data_out_valid(data_out_valid), .data_out(data_out),
    .data_out_ch(data_out_ch), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input int ch, input int sum);
    chk({tag, "_valid"}, {31'd0, data_out_valid}, {31'd0, v});
    chk({tag, "_ch"}, {30'd0, data_out_ch}, ch);
    chk({tag, "_sum"}, {16'd0, data_out}, sum);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; clr = '0; data_in = '0;
    @(negedge clk);
    req = 4'b1111; en = 1'b1;
    #1 chk("rst_gnt_forced_zero", {28'd0, gnt}, 0);
    tick();
    req = '0; en = 1'b0; rst = 1'b0;
    chk_out("reset_state", 1'b0, 0, 0);
    chk("reset_ovf", {28'd0, ovf}, 0);

    // 1: single requester accumulates 5, 10, 20
    en = 1'b1; req = 4'b0001;
    data_in = pack(5, 0, 0, 0);
    #1 chk("t1_gnt_a", {28'd0, gnt}, 4'b0001);
    tick(); chk_out("t1_a", 1'b1, 0, 5);
    data_in = pack(10, 0, 0, 0);
    #1 chk("t1_gnt_b", {28'd0, gnt}, 4'b0001);
    tick(); chk_out("t1_b", 1'b1, 0, 15);
    data_in = pack(20, 0, 0, 0);
    #1 chk("t1_gnt_c", {28'd0, gnt}, 4'b0001);
    tick(); chk_out("t1_c", 1'b1, 0, 35);
    req = '0;
    tick(); chk_out("t1_hold", 1'b0, 0, 35);

    // 2: all requesting, round-robin fairness
    do_reset();
    req = 4'b1111; data_in = pack(1, 2, 3, 4);
    for (int c = 0; c < 8; c++) begin
      #1 chk("t2_gnt", {28'd0, gnt}, 32'd1 << (c % 4));
      tick();
      chk_out("t2_out", 1'b1, c % 4, ((c % 4) + 1) * ((c / 4) + 1));
    end

    // 3: wrap and sticky overflow on channel 1
    do_reset();
    req = 4'b0010; data_in = pack(0, 255, 0, 0);
    for (int c = 0; c < 257; c++) tick();
    chk_out("t3_full", 1'b1, 1, 16'hFFFF);
    chk("t3_no_ovf", {28'd0, ovf}, 0);
    tick(); chk_out("t3_wrap", 1'b1, 1, 16'h00FE);
    chk("t3_ovf_set", {28'd0, ovf}, 4'b0010);
    tick(); chk_out("t3_after", 1'b1, 1, 16'h01FD);
    chk("t3_ovf_sticky", {28'd0, ovf}, 4'b0010);
    req = '0; clr = 4'b0010;
    tick(); chk("t3_ovf_clr", {28'd0, ovf}, 0);
    chk("t3_valid_idle", {31'd0, data_out_valid}, 0);
    clr = '0; req = 4'b0010; data_in = pack(0, 1, 0, 0);
    tick(); chk_out("t3_sum_cleared", 1'b1, 1, 1);

    // 4: clear coinciding with a transfer on the same channel
    do_reset();
    req = 4'b0100; data_in = pack(0, 0, 100, 0);
    tick(); chk_out("t4_pre", 1'b1, 2, 100);
    clr = 4'b0100; data_in = pack(0, 0, 7, 0);
    tick(); chk_out("t4_clr_add", 1'b1, 2, 7);
    chk("t4_ovf", {28'd0, ovf}, 0);
    clr = '0; data_in = pack(0, 0, 3, 0);
    tick(); chk_out("t4_next", 1'b1, 2, 10);

    // 5: mid-operation reset
    do_reset();
    req = 4'b1111; data_in = pack(9, 1, 1, 1);
    tick(); tick();
    #1 chk("t5_gnt_ptr2", {28'd0, gnt}, 4'b0100);
    rst = 1'b1;
    #1 chk("t5_gnt_in_rst", {28'd0, gnt}, 0);
    tick();
    chk_out("t5_no_pulse", 1'b0, 0, 0);
    rst = 1'b0;
    #1 chk("t5_gnt_ptr0", {28'd0, gnt}, 4'b0001);
    tick(); chk_out("t5_first", 1'b1, 0, 9);

    // 6: enable low preserves pointer and sums
    req = 4'b0010; data_in = pack(0, 11, 22, 0);
    #1 chk("t6_gnt_ch1", {28'd0, gnt}, 4'b0010);
    tick(); chk_out("t6_ch1", 1'b1, 1, 11);
    en = 1'b0; req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t6_gnt_off", {28'd0, gnt}, 0);
      tick(); chk_out("t6_idle", 1'b0, 1, 11);
    end
    en = 1'b1;
    #1 chk("t6_resume_gnt", {28'd0, gnt}, 4'b0100);
    tick(); chk_out("t6_resume", 1'b1, 2, 22);
    #1 chk("t6_wrap_gnt", {28'd0, gnt}, 4'b0010);
    tick(); chk_out("t6_wrap", 1'b1, 1, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
